seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, successor to the fixed-pattern seq detector.

---
 rtl/seq_detector_param_if.sv | 27 ++
 rtl/seq_detector_param.sv | 110 +++++++++++
 tb/tb_seq_detector_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Bundle of the serial detector's control, data and status signals.
// The master drives sample/config inputs; the slave (detector) returns status.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               ena;
  logic               input_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   progress;

  modport master (
    output ena, input_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  match, match_count, progress
  );

  modport slave (
    input  ena, input_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output match, match_count, progress
  );
endinterface

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector: shifts input bits into a history
// register and pulses match when the newest len bits equal the loaded pattern.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'hA5),
  parameter int                 DEFAULT_LEN = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_detector_param_if.slave bus
);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               hit;

  // Bit gi of the history takes part in the compare only when gi < len.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      localparam logic [LEN_W:0] IDX = (LEN_W + 1)'(gi);
      assign mask[gi] = ({1'b0, len_q} > IDX);
    end
  endgenerate

  always_comb begin
    cfg_len_clamped = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
      cfg_len_clamped = LEN_W'(MAX_LEN);
    end
  end

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], bus.input_bit};
    // Once armed the fill level saturates at len, so no increment is needed.
    fill_inc   = (state_q == ST_ARMED) ? len_q : fill_q + 1'b1;
    hit        = (fill_inc == len_q) && ((hist_shift & mask) == (pattern_q & mask));

    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    match_d   = 1'b0;

    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      len_d     = cfg_len_clamped;
      overlap_d = bus.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
    end else if (bus.ena) begin
      hist_d  = hist_shift;
      match_d = hit;
      // Non-overlap mode invalidates the history so the next match needs len fresh bits.
      fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
      if (hit && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end

    state_d = (fill_d == len_d) ? ST_ARMED : ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= DEFAULT_PAT;
      len_q     <= LEN_W'(DEFAULT_LEN);
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      state_q   <= ST_FILL;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      match_q   <= match_d;
      state_q   <= state_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.progress    = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: expected status per step is queued when the
// step is driven and compared after the clock edge that consumes it.
module tb_seq_detector_param;

  logic clk;
  logic rst_n;

  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus_a ();
  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus_b ();

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8),
                       .DEFAULT_PAT(8'hA5), .DEFAULT_LEN(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2),
                       .DEFAULT_PAT(8'hA5), .DEFAULT_LEN(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic        m;
    logic [7:0]  cnt;
    logic [3:0]  prog;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input logic ld, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic en, input logic b);
    if (!sel) begin
      bus_a.cfg_load = ld; bus_a.cfg_pattern = pat; bus_a.cfg_len = len;
      bus_a.cfg_overlap = ovl; bus_a.ena = en; bus_a.input_bit = b;
    end else begin
      bus_b.cfg_load = ld; bus_b.cfg_pattern = pat; bus_b.cfg_len = len;
      bus_b.cfg_overlap = ovl; bus_b.ena = en; bus_b.input_bit = b;
    end
  endtask

  task automatic step(input bit sel, input logic ld, input logic [7:0] pat,
                      input logic [3:0] len, input logic ovl, input logic en, input logic b,
                      input logic em, input logic [7:0] ec, input logic [3:0] ep,
                      input string tag);
    exp_t e;
    exp_t got;
    logic       om;
    logic [7:0] oc;
    logic [3:0] op;
    drive(sel, ld, pat, len, ovl, en, b);
    e.m = em; e.cnt = ec; e.prog = ep; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    om = sel ? bus_b.match : bus_a.match;
    oc = sel ? 8'(bus_b.match_count) : bus_a.match_count;
    op = sel ? bus_b.progress : bus_a.progress;
    $display("step %s: ld=%b ena=%b bit=%b -> match=%b count=%0d progress=%0d",
             got.tag, ld, en, b, om, oc, op);
    chk({got.tag, ".match"},    16'(om), 16'(got.m));
    chk({got.tag, ".count"},    16'(oc), 16'(got.cnt));
    chk({got.tag, ".progress"}, 16'(op), 16'(got.prog));
  endtask

  task automatic bit_a(input logic en, input logic b, input logic em,
                       input logic [7:0] ec, input logic [3:0] ep, input string tag);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, en, b, em, ec, ep, tag);
  endtask

  task automatic load_a(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic en, input logic b, input string tag);
    step(1'b0, 1'b1, pat, len, ovl, en, b, 1'b0, 8'd0, 4'd0, tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".match"},    16'(bus_a.match),       16'd0);
    chk({tag, ".count"},    16'(bus_a.match_count), 16'd0);
    chk({tag, ".progress"}, 16'(bus_a.progress),    16'd0);
  endtask

  localparam logic [7:0] STREAM = 8'b1010_1010;
  localparam logic [7:0] PAT_A5 = 8'hA5;

  initial begin
    logic [7:0] s;
    logic [7:0] p;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern A5, len 4: newest four bits must read 0101 (oldest first 0,1,0,1).
    bit_a(1'b1, 1'b0, 1'b0, 8'd0, 4'd1, "dflt1");
    bit_a(1'b1, 1'b1, 1'b0, 8'd0, 4'd2, "dflt2");
    bit_a(1'b1, 1'b0, 1'b0, 8'd0, 4'd3, "dflt3");
    bit_a(1'b1, 1'b1, 1'b1, 8'd1, 4'd4, "dflt4");
    bit_a(1'b1, 1'b1, 1'b0, 8'd1, 4'd4, "dflt5");
    bit_a(1'b1, 1'b0, 1'b0, 8'd1, 4'd4, "pre_rst1");
    bit_a(1'b1, 1'b1, 1'b0, 8'd1, 4'd4, "pre_rst2");
    bit_a(1'b1, 1'b0, 1'b0, 8'd1, 4'd4, "pre_rst3");

    // T1: asynchronous reset mid-stream clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // A retained history would match on this 1; after reset it must not.
    bit_a(1'b1, 1'b1, 1'b0, 8'd0, 4'd1, "post_rst1");
    bit_a(1'b1, 1'b0, 1'b0, 8'd0, 4'd2, "post_rst2");
    bit_a(1'b1, 1'b1, 1'b0, 8'd0, 4'd3, "post_rst3");
    bit_a(1'b1, 1'b0, 1'b0, 8'd0, 4'd4, "post_rst4");
    bit_a(1'b1, 1'b1, 1'b1, 8'd1, 4'd4, "post_rst5");

    // T2: overlapping matches on 1010 repeated.
    load_a(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0, "t2_load");
    s = STREAM;
    for (int i = 0; i < 8; i++) begin
      bit_a(1'b1, s[7-i], (i == 3 || i == 5 || i == 7),
            8'((i >= 3) ? (i - 1) / 2 : 0), 4'((i < 3) ? i + 1 : 4),
            $sformatf("t2_bit%0d", i + 1));
    end

    // T3: non-overlapping; progress drops to 0 after each match.
    load_a(8'h0A, 4'd4, 1'b0, 1'b0, 1'b0, "t3_load");
    for (int i = 0; i < 8; i++) begin
      bit_a(1'b1, s[7-i], (i == 3 || i == 7), 8'((i >= 7) ? 2 : (i >= 3) ? 1 : 0),
            4'((i + 1) % 4), $sformatf("t3_bit%0d", i + 1));
    end

    // T4: ena low inside the pattern holds state and ignores input_bit.
    load_a(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0, "t4_load");
    bit_a(1'b1, 1'b1, 1'b0, 8'd0, 4'd1, "t4_b1");
    bit_a(1'b1, 1'b0, 1'b0, 8'd0, 4'd2, "t4_b2");
    for (int i = 0; i < 3; i++) begin
      bit_a(1'b0, 1'b1, 1'b0, 8'd0, 4'd2, $sformatf("t4_hold%0d", i));
    end
    bit_a(1'b1, 1'b1, 1'b0, 8'd0, 4'd3, "t4_b3");
    bit_a(1'b1, 1'b0, 1'b1, 8'd1, 4'd4, "t4_b4");
    bit_a(1'b0, 1'b0, 1'b0, 8'd1, 4'd4, "t4_idle");

    // T5: len 0 clamps to 1; load with ena=1 drops the bit.
    load_a(8'h01, 4'd0, 1'b1, 1'b1, 1'b1, "t5_load");
    bit_a(1'b1, 1'b1, 1'b1, 8'd1, 4'd1, "t5_b1");
    bit_a(1'b1, 1'b1, 1'b1, 8'd2, 4'd1, "t5_b2");
    bit_a(1'b1, 1'b0, 1'b0, 8'd2, 4'd1, "t5_b3");
    bit_a(1'b1, 1'b1, 1'b1, 8'd3, 4'd1, "t5_b4");

    // Oversized length clamps to MAX_LEN: full 8-bit A5 match.
    load_a(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, "clamp_load");
    p = PAT_A5;
    for (int i = 0; i < 8; i++) begin
      bit_a(1'b1, p[7-i], (i == 7), 8'((i == 7) ? 1 : 0), 4'(i + 1),
            $sformatf("clamp_b%0d", i + 1));
    end
    bit_a(1'b1, 1'b1, 1'b0, 8'd1, 4'd8, "clamp_b9");

    // T6: 2-bit counter saturates at 3 while match keeps pulsing.
    step(1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, "t6_load");
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1,
           8'((i < 3) ? i + 1 : 3), 4'd1, $sformatf("t6_b%0d", i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
